control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  in  1  sole clock; all state changes on rising edge.
REQ-002 clear  in  1  reset, asynchronous, active-high.
REQ-003 Stop  in  1  level request to halt at next instruction boundary.
REQ-004 IRout  in  32  instruction register contents; opcode = IRout[31:27].
REQ-005 CON  in  1  latched branch condition from con_ff.
REQ-006 Run  out  1  high while executing; low in HALT.
REQ-007 Gra, Grb, Grc  out  1 each  register-field selects (ra, rb, rc) for select/encode logic.
REQ-008 Rin, Rout, BAout  out  1 each  selected-register write, bus drive, base-address drive (R0 reads as 0).
REQ-009 Cout  out  1  drive sign-extended IRout[18:0] onto bus.
REQ-010 PCout, PCin, IncPC  out  1 each  PC bus drive, PC load, PC increment.
REQ-011 MARin, MDRin, MDRout  out  1 each  memory address/data register controls.
REQ-012 read, RAMwrite  out  1 each  MDR mux select/RAM read enable, RAM write enable.
REQ-013 IRin, Yin, Zin, Zlowout  out  1 each  IR load, Y load, Z load, Zlow bus drive.
REQ-014 CONin  out  1  load con_ff.
REQ-015 opcode  out  5  ALU operation select.

Function
REQ-016 Moore FSM, one state per clock; all outputs SHALL be decoded from current state and IRout only; unlisted outputs 0; opcode defaults 5'b00011 (add).
REQ-017 Fetch: T0 = PCout, MARin, IncPC, Zin; T1 = Zlowout, PCin, read, MDRin; T2 = MDRout, IRin; T3 = first execute state.
REQ-018 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 01001, shl 01011, addi 01100, andi 01101, ori 01110, br 10011, nop 11010, halt 11011; any other = nop.
REQ-019 R-type (add..shl): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, opcode=IRout[31:27]; T5 Zlowout,Gra,Rin; then T0 (6 cycles).
REQ-020 Immediate (addi/andi/ori): T3 Grb,Rout,Yin; T4 Cout,Zin, opcode = add/and/or respectively; T5 Zlowout,Gra,Rin; then T0.
REQ-021 ldi: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-022 ld: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin; then T0 (8 cycles).
REQ-023 st: T3-T5 as ld; T6 Gra,Rout,MDRin (read=0); T7 RAMwrite; then T0.
REQ-024 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin; T6 Zlowout,PCin only if CON=1, else no strobes; then T0.
REQ-025 nop: T3 asserts nothing; then T0.
REQ-026 halt: T3 -> HALT; HALT asserts nothing, Run=0, holds until clear.
REQ-027 Stop sampled in each instruction's final state; Stop=1 -> HALT instead of T0; mid-instruction Stop never truncates an instruction.
REQ-028 At most one bus driver (Rout, BAout, Cout, PCout, MDRout, Zlowout) SHALL be high in any state.
REQ-029 IRout SHALL be treated as stable from T3 onward; decoding in T0-T2 ignored.

Reset
REQ-030 clear=1 forces state RESET immediately, all outputs 0, Run=1, opcode=5'b00011, including mid-instruction and in HALT.
REQ-031 First rising edge after clear falls: RESET -> T0.

Verification
REQ-032 Release clear, IRout=add r5,r2,r4 (0x1A920000) -> T0..T5 strobes per REQ-019, Rin with Gra in cycle 6, back to T0 cycle 7.
REQ-033 ld r1,0x55(r3) (0x00980055) -> Grb+BAout T3, Cout T4, MARin T5, read+MDRin T6, MDRout+Gra+Rin T7.
REQ-034 br with CON=0 then CON=1 -> PCin absent vs present in T6; both return to T0 after T6.
REQ-035 halt (0xD8000000) -> Run falls after T3, no strobes for 20 cycles; clear -> Run=1, fetch resumes.
REQ-036 Stop raised during T4 of addi -> T5 completes with Rin, then HALT, Run=0.
REQ-037 clear pulsed during st T6 -> outputs 0 same cycle, RAMwrite never asserted, fetch restarts at T0.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch T0-T2, per-class execute T3-T7, HALT.
// Strobes decode from the current state and IRout; branch PC load in T6 also uses CON.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic        Stop,
    input  logic [31:0] IRout,
    input  logic        CON,
    output logic        Run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        read,
    output logic        RAMwrite,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        CONin,
    output logic [4:0]  opcode
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;

    state_t     state;
    state_t     next_state;
    logic [4:0] ir_op;
    logic       is_rtype, is_imm, is_ldi, is_ld, is_st, is_br, is_halt, is_nop;
    logic       last_state;
    logic [4:0] imm_alu;
    logic       unused_ir;

    assign ir_op     = IRout[31:27];
    assign unused_ir = ^IRout[26:0];

    always_comb begin
        is_rtype = 1'b0;
        is_imm   = 1'b0;
        is_ldi   = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        is_br    = 1'b0;
        is_halt  = 1'b0;
        imm_alu  = OP_ADD;
        case (ir_op)
            5'b00000: is_ld = 1'b1;
            5'b00001: is_ldi = 1'b1;
            5'b00010: is_st = 1'b1;
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01001, 5'b01011: is_rtype = 1'b1;
            5'b01100: is_imm = 1'b1;
            5'b01101: begin is_imm = 1'b1; imm_alu = OP_AND; end
            5'b01110: begin is_imm = 1'b1; imm_alu = OP_OR;  end
            5'b10011: is_br = 1'b1;
            5'b11011: is_halt = 1'b1;
            default: ;
        endcase
        is_nop = ~(is_rtype | is_imm | is_ldi | is_ld | is_st | is_br | is_halt);
    end

    // Stop is only honoured in the final state of each instruction class.
    assign last_state = (state == S_T3 && is_nop)
                      || (state == S_T5 && (is_rtype || is_imm || is_ldi))
                      || (state == S_T6 && is_br)
                      || (state == S_T7 && (is_ld || is_st));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_RESET;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        Run = 1'b1;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        read = 1'b0; RAMwrite = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        CONin = 1'b0;
        opcode = OP_ADD;

        case (state)
            S_RESET: next_state = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                next_state = S_T4;
                if (is_rtype || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (is_halt) begin
                    next_state = S_HALT;
                end
            end
            S_T4: begin
                next_state = S_T5;
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = imm_alu;
                end else if (is_ldi || is_ld || is_st) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                next_state = S_T6;
                if (is_rtype || is_imm || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1;
                end
            end
            S_T6: begin
                next_state = S_T7;
                if (is_ld) begin
                    read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br && CON) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                next_state = S_T0;
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    RAMwrite = 1'b1;
                end
            end
            S_HALT: Run = 1'b0;
            default: next_state = S_RESET;
        endcase

        if (last_state) next_state = Stop ? S_HALT : S_T0;
    end

endmodule
